// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, FSM states,
// requester IDs and the request bundle carried onto the ALU operand bus.
package alu_pkg;

    localparam int DW  = 16;
    localparam int OPW = 3;

    localparam logic [OPW-1:0] ALU_ADD   = 3'd0;
    localparam logic [OPW-1:0] ALU_AND   = 3'd1;
    localparam logic [OPW-1:0] ALU_XOR   = 3'd2;
    localparam logic [OPW-1:0] ALU_SHL   = 3'd3;
    localparam logic [OPW-1:0] ALU_SHR   = 3'd4;
    localparam logic [OPW-1:0] ALU_SRA   = 3'd5;
    localparam logic [OPW-1:0] ALU_PASSA = 3'd6;
    localparam logic [OPW-1:0] ALU_PASSB = 3'd7;

    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_AGU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        PSR  = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic           setcc;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the holder of `last` loses a tie.
// Purely combinational, the history register belongs to the caller.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || last == REQ_AGU))
                grant = 2'b01;
            else if (req[1])
                grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the single datapath ALU between the execute unit, the address unit
// and the PSR-restore path, one operation at a time.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req0_setcc,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic           req1_setcc,
    input  logic           psr_load_valid,
    output logic           psr_load_ready,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic           alu_flag,
    output logic           alu_frm_mem,
    input  logic [DW-1:0]  alu_result,
    output logic           resp_valid,
    output logic           resp_id,
    output logic [DW-1:0]  resp_data,
    input  logic           resp_ready
);

    state_e   state, state_nxt;
    logic     last;
    logic     gnt_setcc;
    logic     idle_ok;
    logic [1:0] grant;
    alu_req_t req_sel;

    // Readies stay low while reset is held even though the state reads IDLE.
    assign idle_ok        = (state == IDLE) && !rst;
    assign psr_load_ready = idle_ok && psr_load_valid;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .last  (last),
        .en    (idle_ok && !psr_load_valid),
        .grant (grant)
    );

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign alu_flag    = (state == EXEC) && gnt_setcc;
    assign alu_frm_mem = (state == PSR);
    assign resp_valid  = (state == RESP);

    always_comb begin
        if (grant[1])
            req_sel = '{op: req1_op, a: req1_a, b: req1_b, setcc: req1_setcc};
        else
            req_sel = '{op: req0_op, a: req0_a, b: req0_b, setcc: req0_setcc};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (psr_load_ready)
                    state_nxt = PSR;
                else if (|grant)
                    state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            PSR:     state_nxt = IDLE;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= REQ_AGU;
            gnt_setcc <= 1'b0;
            alu_op    <= ALU_PASSA;
            alu_a     <= '0;
            alu_b     <= '0;
            resp_id   <= REQ_EXU;
            resp_data <= '0;
        end else begin
            state <= state_nxt;
            if (|grant) begin
                last      <= grant[1];
                gnt_setcc <= req_sel.setcc;
                alu_op    <= req_sel.op;
                alu_a     <= req_sel.a;
                alu_b     <= req_sel.b;
            end
            // ALU latched the result at the mid-cycle falling edge of EXEC.
            if (state == EXEC) begin
                resp_data <= alu_result;
                resp_id   <= last;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU on the falling edge,
// directed table vectors, multi-cycle corner sequences and random operations.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_setcc, req1_setcc;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        psr_load_valid, resp_ready;
    logic [15:0] alu_result = 16'h0;
    logic        req0_ready, req1_ready, psr_load_ready;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, resp_data;
    logic        alu_flag, alu_frm_mem, resp_valid, resp_id;

    logic [2:0]  znp = 3'b000;            // {N,Z,P} held by the ALU model
    localparam logic [2:0] MDR_ZNP = 3'b100;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_setcc(req1_setcc),
        .psr_load_valid(psr_load_valid), .psr_load_ready(psr_load_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_flag(alu_flag), .alu_frm_mem(alu_frm_mem), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready)
    );

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa;
        sa = $signed(a);
        case (op)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return a ^ b;
            3'd3: return (b >= 16) ? 16'h0 : 16'(a << b[3:0]);
            3'd4: return (b >= 16) ? 16'h0 : 16'(a >> b[3:0]);
            3'd5: return (b >= 16) ? {16{a[15]}} : 16'(sa >>> b[3:0]);
            3'd6: return a;
            default: return b;
        endcase
    endfunction

    function automatic logic [2:0] flags_of(input logic [15:0] r);
        return {r[15], r == 16'h0, !r[15] && r != 16'h0};
    endfunction

    always @(negedge clk) begin
        alu_result <= ref_alu(alu_op, alu_a, alu_b);
        if (alu_frm_mem)   znp <= MDR_ZNP;
        else if (alu_flag) znp <= flags_of(ref_alu(alu_op, alu_a, alu_b));
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; psr_load_valid = 0; resp_ready = 0;
    endtask

    // Leaves time at rising edge + 2, the common drive point.
    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
    endtask

    // One complete transaction from a drive point; returns at a drive point.
    task automatic run_op(input logic id, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic sc, input int hold,
                          output logic [15:0] d, output logic rid, output int fl);
        int n;
        logic [15:0] d0;
        d = 16'h0; rid = 1'b0; fl = 0; resp_ready = 0;
        if (id) begin
            req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req1_setcc = sc;
        end else begin
            req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_setcc = sc;
        end
        #1; n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(posedge clk); #3; n++;
        end
        if (n >= 20) begin
            chk("grant_timeout", 16'd1, 16'd0);
            idle_inputs(); @(posedge clk); #2; return;
        end
        @(posedge clk); #2;
        req0_valid = 0; req1_valid = 0;
        #1; n = 0;
        forever begin
            if (alu_flag) fl++;
            if (resp_valid || n >= 20) break;
            @(posedge clk); #3; n++;
        end
        if (n >= 20) begin
            chk("resp_timeout", 16'd1, 16'd0);
            @(posedge clk); #2; return;
        end
        d0 = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #3;
            if (alu_flag) fl++;
            chk("resp_hold_valid", 16'(resp_valid), 16'd1);
            chk("resp_hold_data", resp_data, d0);
        end
        d = resp_data; rid = resp_id;
        resp_ready = 1;
        @(posedge clk); #2;
        resp_ready = 0;
    endtask

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        sc;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [15:0] d, exp_d;
        logic        rid, exp_id, have_exp, gnt_now, gnt_who;
        int          fl, ng, nr, n;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        id, sc;
        logic        gq[$];

        tbl[0] = '{1'b0, 3'd0, 16'd5,    16'hFFFD, 1'b1, 16'h0002};
        tbl[1] = '{1'b1, 3'd1, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030};
        tbl[2] = '{1'b0, 3'd2, 16'h00FF, 16'h0F0F, 1'b1, 16'h0FF0};
        tbl[3] = '{1'b1, 3'd3, 16'h0001, 16'd16,   1'b0, 16'h0000};
        tbl[4] = '{1'b0, 3'd4, 16'h8000, 16'd15,   1'b1, 16'h0001};
        tbl[5] = '{1'b1, 3'd5, 16'h8000, 16'd4,    1'b0, 16'hF800};
        tbl[6] = '{1'b0, 3'd6, 16'h1234, 16'h5678, 1'b0, 16'h1234};
        tbl[7] = '{1'b1, 3'd7, 16'h1234, 16'h5678, 1'b1, 16'h5678};
        tbl[8] = '{1'b0, 3'd5, 16'h8001, 16'd100,  1'b1, 16'hFFFF};
        tbl[9] = '{1'b1, 3'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000};

        // Reset state, with every request input active during reset
        rst = 1;
        req0_valid = 1; req1_valid = 1; psr_load_valid = 1; resp_ready = 1;
        req0_op = 0; req0_a = 0; req0_b = 0; req0_setcc = 0;
        req1_op = 0; req1_a = 0; req1_b = 0; req1_setcc = 0;
        #3;
        chk("rst_req0_ready", 16'(req0_ready), 16'd0);
        chk("rst_req1_ready", 16'(req1_ready), 16'd0);
        chk("rst_psr_ready", 16'(psr_load_ready), 16'd0);
        chk("rst_alu_op", 16'(alu_op), 16'd6);
        chk("rst_alu_a", alu_a, 16'd0);
        chk("rst_alu_b", alu_b, 16'd0);
        chk("rst_flag", 16'({alu_flag, alu_frm_mem}), 16'd0);
        chk("rst_resp", 16'({resp_valid, resp_id}), 16'd0);
        chk("rst_resp_data", resp_data, 16'd0);
        do_reset();

        // Directed vectors, including shift amounts at and beyond the width
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sc, i % 3, d, rid, fl);
            chk($sformatf("vec%0d_data", i), d, tbl[i].exp);
            chk($sformatf("vec%0d_id", i), 16'(rid), 16'(tbl[i].id));
            chk($sformatf("vec%0d_flagcyc", i), 16'(fl), 16'(tbl[i].sc));
            if (tbl[i].sc)
                chk($sformatf("vec%0d_znp", i), 16'(znp), 16'(flags_of(tbl[i].exp)));
        end

        // PSR restore wins over a simultaneous requester
        psr_load_valid = 1;
        req1_valid = 1; req1_op = 3'd5; req1_a = 16'h8000; req1_b = 16'd4; req1_setcc = 0;
        #1;
        chk("psr_ready", 16'(psr_load_ready), 16'd1);
        chk("psr_req1_wait", 16'(req1_ready), 16'd0);
        @(posedge clk); #2;
        psr_load_valid = 0;
        #1;
        chk("psr_frm_mem", 16'(alu_frm_mem), 16'd1);
        chk("psr_flag", 16'(alu_flag), 16'd0);
        chk("psr_req1_still_wait", 16'(req1_ready), 16'd0);
        @(posedge clk); #2;
        run_op(1'b1, 3'd5, 16'h8000, 16'd4, 1'b0, 0, d, rid, fl);
        chk("psr_then_req1_data", d, 16'hF800);
        chk("psr_then_req1_id", 16'(rid), 16'd1);
        chk("psr_znp_loaded", 16'(znp), 16'(MDR_ZNP));

        // Response back-pressure holds data and blocks new grants
        req0_valid = 1; req0_op = 3'd2; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_setcc = 0;
        #1;
        chk("bp_grant", 16'(req0_ready), 16'd1);
        @(posedge clk); #2;
        req0_valid = 0;
        req1_valid = 1; req1_op = 3'd6; req1_a = 16'h0ABC; req1_b = 16'h0; req1_setcc = 0;
        #1;
        chk("bp_exec_block", 16'(req1_ready), 16'd0);
        @(posedge clk); #2;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 16'(resp_valid), 16'd1);
            chk("bp_data", resp_data, 16'h0FF0);
            chk("bp_id", 16'(resp_id), 16'd0);
            chk("bp_block", 16'(req1_ready), 16'd0);
            @(posedge clk); #2;
        end
        resp_ready = 1;
        #1;
        chk("bp_handshake_nogrant", 16'(req1_ready), 16'd0);
        @(posedge clk); #2;
        resp_ready = 0;
        #1;
        chk("bp_after_idle", 16'(resp_valid), 16'd0);
        chk("bp_after_grant", 16'(req1_ready), 16'd1);
        @(posedge clk); #2;
        req1_valid = 0; resp_ready = 1;
        repeat (3) begin @(posedge clk); #2; end
        resp_ready = 0;

        // Reset in the middle of EXEC abandons the operation
        req0_valid = 1; req0_op = 3'd7; req0_a = 16'h0; req0_b = 16'h4444; req0_setcc = 1;
        #1;
        chk("rx_grant", 16'(req0_ready), 16'd1);
        @(posedge clk); #2;
        req0_valid = 0;
        #1;
        chk("rx_exec_b", alu_b, 16'h4444);
        chk("rx_exec_flag", 16'(alu_flag), 16'd1);
        rst = 1;
        #1;
        chk("rx_alu_op", 16'(alu_op), 16'd6);
        chk("rx_alu_b", alu_b, 16'd0);
        chk("rx_flag", 16'(alu_flag), 16'd0);
        chk("rx_resp", 16'(resp_valid), 16'd0);
        @(posedge clk); #2;
        rst = 0;
        nr = 0;
        for (int i = 0; i < 3; i++) begin
            #1; if (resp_valid) nr++;
            @(posedge clk); #2;
        end
        chk("rx_no_resp", 16'(nr), 16'd0);
        req0_valid = 1; req1_valid = 1; req0_setcc = 0; req1_setcc = 0;
        #1;
        chk("rx_next_req0", 16'(req0_ready), 16'd1);
        chk("rx_next_not_req1", 16'(req1_ready), 16'd0);
        @(posedge clk); #2;
        idle_inputs(); resp_ready = 1;
        repeat (3) begin @(posedge clk); #2; end
        resp_ready = 0;

        // Continuous contention: grants alternate starting with requester 0
        do_reset();
        resp_ready = 1;
        req0_valid = 1; req0_op = 3'd0; req0_a = 16'(100); req0_b = 16'(7); req0_setcc = 0;
        req1_valid = 1; req1_op = 3'd2; req1_a = 16'hAAAA; req1_b = 16'h0F0F; req1_setcc = 1;
        ng = 0; nr = 0; n = 0; have_exp = 0; exp_id = 0; exp_d = 0;
        while ((ng < 6 || have_exp) && n < 60) begin
            #1;
            chk("rr_one_ready", 16'(req0_ready & req1_ready), 16'd0);
            if (resp_valid) begin
                chk("rr_resp_pending", 16'(have_exp), 16'd1);
                chk("rr_resp_id", 16'(resp_id), 16'(exp_id));
                chk("rr_resp_data", resp_data, exp_d);
                have_exp = 0; nr++;
            end
            gnt_now = req0_ready | req1_ready;
            gnt_who = req1_ready;
            if (gnt_now) begin
                gq.push_back(gnt_who);
                exp_id = gnt_who; have_exp = 1; ng++;
                exp_d = gnt_who ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
            end
            @(posedge clk); #2;
            if (gnt_now && !gnt_who) begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
            if (gnt_now &&  gnt_who) begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
            if (ng >= 6) begin req0_valid = 0; req1_valid = 0; end
            n++;
        end
        chk("rr_grants", 16'(gq.size()), 16'd6);
        chk("rr_resps", 16'(nr), 16'd6);
        foreach (gq[i]) chk($sformatf("rr_grant%0d", i), 16'(gq[i]), 16'(i % 2));
        resp_ready = 0;

        // Random single operations against the reference model
        for (int i = 0; i < 40; i++) begin
            id = 1'($urandom);
            op = 3'($urandom);
            a  = 16'($urandom);
            b  = ($urandom % 2) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            sc = 1'($urandom);
            run_op(id, op, a, b, sc, $urandom_range(0, 3), d, rid, fl);
            chk($sformatf("rnd%0d_data", i), d, ref_alu(op, a, b));
            chk($sformatf("rnd%0d_id", i), 16'(rid), 16'(id));
            chk($sformatf("rnd%0d_flagcyc", i), 16'(fl), 16'(sc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing controller that shares the single 16-bit datapath ALU between two requesters (requester 0: execute unit, requester 1: address/PC-update unit) and the PSR-restore path. It accepts one operation at a time over valid/ready handshakes, drives the ALU operand, opcode, flag-update and PSR-load controls for exactly one cycle, captures the latched ALU result and returns it to the requester that issued it. It sits between the control unit and the ALU, replacing direct control-unit drive of the ALU inputs.

## Interface
- No parameters; data width is fixed at 16 and the opcode width at 3.
- clk  in  1  system clock; the ALU latches its result on the falling edge, and this block acts on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  operation request.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  3  ALU opcode: ADD, AND, XOR, SHL, SHR, SRA, PASSA, PASSB = 0..7.
- req0_a, req0_b / req1_a, req1_b  in  16  signed operands.
- req0_setcc / req1_setcc  in  1  update Z/N/P from the result.
- psr_load_valid  in  1  request to restore Z/N/P from the memory data register.
- psr_load_ready  out  1  PSR restore accepted.
- alu_op  out  3  opcode driven to the ALU.
- alu_a, alu_b  out  16  operands driven to the ALU.
- alu_flag  out  1  ALU condition-code update enable.
- alu_frm_mem  out  1  ALU PSR-from-memory enable.
- alu_result  in  16  ALU latched output.
- resp_valid  out  1  result available.
- resp_id  out  1  requester that owns the result.
- resp_data  out  16  captured result.
- resp_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, EXEC, PSR, RESP.
- **IDLE**
  - psr_load_valid has the highest priority: assert psr_load_ready and go to PSR.
  - Otherwise, grant by round-robin between the valid requesters: assert reqN_ready for the winner only, register its op, a, b and setcc onto the ALU outputs, and go to EXEC.
  - The ready outputs are combinational from the valid inputs and the state; at most one ready is high per cycle.
- **Round-robin rule**
  - A register `last` holds the ID of the last granted requester.
  - When both requesters are valid, the one that is not `last` wins; a lone valid requester always wins.
  - `last` is updated only on a grant.
- **EXEC** (exactly 1 cycle)
  - alu_op/a/b are held; alu_flag = the granted setcc.
  - At the next rising edge, capture alu_result into resp_data, set resp_id, and go to RESP.
- **PSR** (exactly 1 cycle)
  - alu_frm_mem = 1 and alu_flag = 0; operands are unchanged.
  - No response is generated; return to IDLE.
- **RESP**
  - resp_valid = 1, with resp_data and resp_id held stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE; no new grant is made in that same cycle.
- alu_flag and alu_frm_mem are high only in EXEC and PSR respectively, and are never high together.

## Timing
- Reset values: state IDLE; `last` = 1 (so requester 0 wins the first contention); alu_op = PASSA (6); alu_a = alu_b = 0; alu_flag = alu_frm_mem = 0; resp_valid = 0; resp_id = 0; resp_data = 0. All ready outputs are low during reset.
- Latency: accepted at rising edge k → EXEC during cycle k..k+1 (the ALU latches at the mid-cycle negedge) → resp_valid high from edge k+1. With resp_ready held high, throughput is one operation per 3 cycles.
- Simultaneous psr_load_valid and reqN_valid in IDLE: PSR is served first, and the requester waits.
- A requester must hold valid and its operands until ready. Dropping valid before ready is legal; no grant is made for it.
- Reset mid-EXEC or mid-PSR: the operation is abandoned and no response is produced. ALU flags may already have updated at that negedge; this is accepted.
- Reset during RESP: the response is discarded.
- The ALU shift amount is the full 16-bit b; amounts of 16 or more yield 0 (or sign fill for SRA). This block passes operands through unmodified.

## Structure
- Shared package `alu_pkg`:
  - opcode constants ALU_ADD … ALU_PASSB;
  - state encoding IDLE/EXEC/PSR/RESP;
  - requester ID constants REQ_EXU = 0, REQ_AGU = 1.
- Sub-module `rr_arb2`: a two-input round-robin arbiter, with inputs req[1:0], last and en, and output grant[1:0] (one-hot or zero). It is purely combinational; `last` lives in alu_arbiter.

## Test plan
- Reset release, then req0 ADD a = 5, b = −3, setcc = 1 → req0_ready for 1 cycle; alu_flag high for exactly 1 cycle; resp_valid with resp_id = 0, resp_data = 2; Z = 0, P = 1 at the ALU.
- Both requesters valid every cycle, resp_ready tied high, 6 operations → grants 0, 1, 0, 1, 0, 1; every response is tagged correctly.
- psr_load_valid together with req1_valid (SRA a = 0x8000, b = 4) → the PSR cycle comes first with alu_frm_mem = 1; then req1 is served, resp_data = 0xF800.
- resp_ready held low for 5 cycles after XOR 0x00FF ^ 0x0F0F → resp_data = 0x0FF0 held stable and resp_valid held high; no requester ready until the handshake completes.
- rst asserted during EXEC → all outputs return to their reset values immediately, no response is produced, and the next grant goes to req0.
- SHL a = 1, b = 16 with setcc = 0 → resp_data = 0 and alu_flag never asserted.
